// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tank_pkg
//  Description : Shared types and constants for the multi-bullet tank
//                controller: direction encoding, keycodes for both key
//                maps, and the bullet spawn offset for a facing direction.
//  Revision    : 1.0 - initial release
// ============================================================================
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  // Key map 0: W/A/S/D + Space
  localparam logic [7:0] c_key_w     = 8'h1A;
  localparam logic [7:0] c_key_a     = 8'h04;
  localparam logic [7:0] c_key_s     = 8'h16;
  localparam logic [7:0] c_key_d     = 8'h07;
  localparam logic [7:0] c_key_space = 8'h2C;

  // Key map 1: arrows + Enter
  localparam logic [7:0] c_key_arrow_up    = 8'h52;
  localparam logic [7:0] c_key_arrow_left  = 8'h50;
  localparam logic [7:0] c_key_arrow_down  = 8'h51;
  localparam logic [7:0] c_key_arrow_right = 8'h4F;
  localparam logic [7:0] c_key_enter       = 8'h28;

  typedef struct packed {
    logic signed [11:0] dx;
    logic signed [11:0] dy;
  } offset_t;

  // Offset of the bullet's top-left corner from the tank's top-left corner
  // so that the bullet appears centred just outside the tank's leading face.
  function automatic offset_t spawn_offset(dir_t d, int ts, int bs);
    offset_t o;
    logic signed [11:0] mid;
    mid = 12'(ts / 2) - 12'(bs / 2);
    o   = '0;
    case (d)
      DIR_UP:    begin o.dx = mid;       o.dy = -12'(bs); end
      DIR_RIGHT: begin o.dx = 12'(ts);   o.dy = mid;      end
      DIR_LEFT:  begin o.dx = -12'(bs);  o.dy = mid;      end
      DIR_DOWN:  begin o.dx = mid;       o.dy = 12'(ts);  end
      default:   begin o.dx = mid;       o.dy = -12'(bs); end
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tank_bullet_slot.sv
`default_nettype none
// ============================================================================
//  Module      : tank_bullet_slot
//  Description : One bullet: valid flag, position and direction, per-frame
//                step or retire at the screen edge, kill input from the
//                collision logic, and pixel hit for rendering.
//  Revision    : 1.0 - initial release
// ============================================================================
module tank_bullet_slot
  import tank_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BULLET_SIZE = 8,
  parameter int BULLET_STEP = 5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       tick,
  input  logic       load,
  input  logic [9:0] load_x,
  input  logic [9:0] load_y,
  input  logic [2:0] load_dir,
  input  logic       kill,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       valid,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [2:0] dir,
  output logic       hit
);

  localparam logic [10:0] c_step  = 11'(BULLET_STEP);
  localparam logic [10:0] c_reach = 11'(BULLET_SIZE + BULLET_STEP);
  localparam logic [10:0] c_bs    = 11'(BULLET_SIZE);
  localparam logic [10:0] c_w     = 11'(SCREEN_W);
  localparam logic [10:0] c_h     = 11'(SCREEN_H);

  logic       r_valid;
  logic [9:0] r_x;
  logic [9:0] r_y;
  dir_t       r_dir;

  logic       w_retire;
  logic [9:0] w_next_x;
  logic [9:0] w_next_y;
  logic [10:0] w_x11;
  logic [10:0] w_y11;

  assign w_x11 = {1'b0, r_x};
  assign w_y11 = {1'b0, r_y};

  // Next position one step ahead, or retire if that step leaves the screen
  always_comb begin
    w_retire = 1'b0;
    w_next_x = r_x;
    w_next_y = r_y;
    case (r_dir)
      DIR_UP: begin
        if (w_y11 < c_step) w_retire = 1'b1;
        else                w_next_y = r_y - c_step[9:0];
      end
      DIR_DOWN: begin
        if (w_y11 + c_reach > c_h) w_retire = 1'b1;
        else                       w_next_y = r_y + c_step[9:0];
      end
      DIR_LEFT: begin
        if (w_x11 < c_step) w_retire = 1'b1;
        else                w_next_x = r_x - c_step[9:0];
      end
      DIR_RIGHT: begin
        if (w_x11 + c_reach > c_w) w_retire = 1'b1;
        else                       w_next_x = r_x + c_step[9:0];
      end
      default: w_retire = 1'b0;
    endcase
  end

  // Slot state: allocation, kill (beats a same-tick move), then per-frame motion
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_dir   <= DIR_UP;
    end else if (load) begin
      r_valid <= 1'b1;
      r_x     <= load_x;
      r_y     <= load_y;
      r_dir   <= dir_t'(load_dir);
    end else if (kill && r_valid) begin
      r_valid <= 1'b0;
    end else if (tick && r_valid) begin
      if (w_retire) begin
        r_valid <= 1'b0;
      end else begin
        r_x <= w_next_x;
        r_y <= w_next_y;
      end
    end
  end

  assign valid = r_valid;
  assign pos_x = r_x;
  assign pos_y = r_y;
  assign dir   = r_dir;

  assign hit = r_valid
            && ({1'b0, DrawX} >= w_x11) && ({1'b0, DrawX} < w_x11 + c_bs)
            && ({1'b0, DrawY} >= w_y11) && ({1'b0, DrawY} < w_y11 + c_bs);

endmodule
`default_nettype wire

// File: rtl/tank_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tank_ctrl_multi
//  Description : Player tank with a pool of bullet slots. Frame-strobe
//                synchroniser, key decode, clamped tank motion, edge-triggered
//                fire with cooldown, slot allocator and render hit logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tank_ctrl_multi
  import tank_pkg::*;
#(
  parameter int X_START     = 100,
  parameter int Y_START     = 240,
  parameter int KEYSET      = 0,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int TANK_SIZE   = 32,
  parameter int BULLET_SIZE = 8,
  parameter int TANK_STEP   = 1,
  parameter int BULLET_STEP = 5,
  parameter int NUM_BULLETS = 4,
  parameter int COOLDOWN    = 15
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_clk,
  input  logic [7:0]               keycode,
  input  logic                     can_move,
  input  logic [NUM_BULLETS-1:0]   bullet_kill,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  output logic [9:0]               tank_X,
  output logic [9:0]               tank_Y,
  output logic [2:0]               tank_dir,
  output logic [NUM_BULLETS-1:0]   bullet_valid,
  output logic [10*NUM_BULLETS-1:0] bullet_X,
  output logic [10*NUM_BULLETS-1:0] bullet_Y,
  output logic [3*NUM_BULLETS-1:0] bullet_dir,
  output logic                     is_tank,
  output logic                     is_bullet,
  output logic [2:0]               bullet_idx
);

  localparam int c_cd_w = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [c_cd_w-1:0] c_cd_load = c_cd_w'(COOLDOWN);
  localparam logic [c_cd_w-1:0] c_cd_one  = c_cd_w'(1);

  localparam logic [10:0] c_tstep = 11'(TANK_STEP);
  localparam logic [10:0] c_ts    = 11'(TANK_SIZE);
  localparam logic [10:0] c_xmax  = 11'(SCREEN_W - TANK_SIZE);
  localparam logic [10:0] c_ymax  = 11'(SCREEN_H - TANK_SIZE);

  localparam logic signed [11:0] c_bs_s = 12'(BULLET_SIZE);
  localparam logic signed [11:0] c_w_s  = 12'(SCREEN_W);
  localparam logic signed [11:0] c_h_s  = 12'(SCREEN_H);

  localparam logic [7:0] c_k_up    = (KEYSET == 0) ? c_key_w     : c_key_arrow_up;
  localparam logic [7:0] c_k_left  = (KEYSET == 0) ? c_key_a     : c_key_arrow_left;
  localparam logic [7:0] c_k_down  = (KEYSET == 0) ? c_key_s     : c_key_arrow_down;
  localparam logic [7:0] c_k_right = (KEYSET == 0) ? c_key_d     : c_key_arrow_right;
  localparam logic [7:0] c_k_fire  = (KEYSET == 0) ? c_key_space : c_key_enter;

  logic r_fs1, r_fs2, r_fs3, r_tick;
  logic [9:0] r_tank_x, r_tank_y;
  dir_t       r_tank_dir;
  logic [c_cd_w-1:0] r_cooldown;
  logic       r_fire_prev;

  logic       w_dir_key, w_fire_key;
  dir_t       w_key_dir;
  logic [10:0] w_x11, w_y11, w_x_inc, w_y_inc;
  logic [9:0] w_next_x, w_next_y;
  offset_t    w_off;
  logic signed [11:0] w_sx, w_sy;
  logic       w_spawn_ok, w_accept, w_any_free;
  logic [2:0] w_free_idx;
  logic [NUM_BULLETS-1:0] w_valid, w_load, w_hit;

  // Frame strobe: two-flop synchroniser, edge flop, registered one-cycle tick.
  // Flops reset high so a strobe already high at reset release is not a rise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fs1  <= 1'b1;
      r_fs2  <= 1'b1;
      r_fs3  <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_fs1  <= frame_clk;
      r_fs2  <= r_fs1;
      r_fs3  <= r_fs2;
      r_tick <= r_fs2 & ~r_fs3;
    end
  end

  // Key decode: direction keys and the fire key for the selected key map
  always_comb begin
    w_dir_key = 1'b1;
    w_key_dir = DIR_UP;
    if (keycode == c_k_up)         w_key_dir = DIR_UP;
    else if (keycode == c_k_right) w_key_dir = DIR_RIGHT;
    else if (keycode == c_k_left)  w_key_dir = DIR_LEFT;
    else if (keycode == c_k_down)  w_key_dir = DIR_DOWN;
    else                           w_dir_key = 1'b0;
  end
  assign w_fire_key = (keycode == c_k_fire);

  assign w_x11   = {1'b0, r_tank_x};
  assign w_y11   = {1'b0, r_tank_y};
  assign w_x_inc = w_x11 + c_tstep;
  assign w_y_inc = w_y11 + c_tstep;

  // Candidate tank position one step in the key direction, clamped to the screen
  always_comb begin
    w_next_x = r_tank_x;
    w_next_y = r_tank_y;
    case (w_key_dir)
      DIR_UP:    w_next_y = (w_y11 < c_tstep) ? 10'd0 : r_tank_y - c_tstep[9:0];
      DIR_LEFT:  w_next_x = (w_x11 < c_tstep) ? 10'd0 : r_tank_x - c_tstep[9:0];
      DIR_DOWN:  w_next_y = (w_y_inc > c_ymax) ? c_ymax[9:0] : w_y_inc[9:0];
      DIR_RIGHT: w_next_x = (w_x_inc > c_xmax) ? c_xmax[9:0] : w_x_inc[9:0];
      default:   w_next_x = r_tank_x;
    endcase
  end

  // Spawn point from the pre-tick position and facing; reject if off-screen
  assign w_off = spawn_offset(r_tank_dir, TANK_SIZE, BULLET_SIZE);
  assign w_sx  = $signed({2'b00, r_tank_x}) + $signed(w_off.dx);
  assign w_sy  = $signed({2'b00, r_tank_y}) + $signed(w_off.dy);
  assign w_spawn_ok = (w_sx >= 12'sd0) && ((w_sx + c_bs_s) <= c_w_s)
                   && (w_sy >= 12'sd0) && ((w_sy + c_bs_s) <= c_h_s);

  // Allocator: lowest-index free slot
  always_comb begin
    w_free_idx = 3'd0;
    w_any_free = 1'b0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_free_idx = 3'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign w_accept = r_tick & w_fire_key & ~r_fire_prev
                  & (r_cooldown == '0) & w_any_free;

  // Tank motion, fire edge memory and cooldown, all advanced once per frame
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tank_x    <= 10'(X_START);
      r_tank_y    <= 10'(Y_START);
      r_tank_dir  <= DIR_UP;
      r_cooldown  <= '0;
      r_fire_prev <= 1'b0;
    end else if (r_tick) begin
      if (w_dir_key) begin
        r_tank_dir <= w_key_dir;
        if (can_move) begin
          r_tank_x <= w_next_x;
          r_tank_y <= w_next_y;
        end
      end
      r_fire_prev <= w_fire_key;
      if (w_accept)               r_cooldown <= c_cd_load;
      else if (r_cooldown != '0)  r_cooldown <= r_cooldown - c_cd_one;
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    assign w_load[i] = w_accept & w_spawn_ok & (w_free_idx == 3'(i));

    tank_bullet_slot #(
      .SCREEN_W    (SCREEN_W),
      .SCREEN_H    (SCREEN_H),
      .BULLET_SIZE (BULLET_SIZE),
      .BULLET_STEP (BULLET_STEP)
    ) u_slot (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .tick     (r_tick),
      .load     (w_load[i]),
      .load_x   (w_sx[9:0]),
      .load_y   (w_sy[9:0]),
      .load_dir (r_tank_dir),
      .kill     (bullet_kill[i]),
      .DrawX    (DrawX),
      .DrawY    (DrawY),
      .valid    (w_valid[i]),
      .pos_x    (bullet_X[10*i +: 10]),
      .pos_y    (bullet_Y[10*i +: 10]),
      .dir      (bullet_dir[3*i +: 3]),
      .hit      (w_hit[i])
    );
  end

  // Render: lowest-index bullet wins where bullets overlap
  always_comb begin
    bullet_idx = 3'd0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (w_hit[i]) bullet_idx = 3'(i);
    end
  end
  assign is_bullet = |w_hit;

  assign is_tank = ({1'b0, DrawX} >= w_x11) && ({1'b0, DrawX} < w_x11 + c_ts)
                && ({1'b0, DrawY} >= w_y11) && ({1'b0, DrawY} < w_y11 + c_ts);

  assign tank_X       = r_tank_x;
  assign tank_Y       = r_tank_y;
  assign tank_dir     = r_tank_dir;
  assign bullet_valid = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_tank_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tank_ctrl_multi
//  Description : Self-checking bench for tank_ctrl_multi (KEYSET 0, defaults).
//                Expected values are queued when stimulus is applied and
//                popped for comparison once the frame has been processed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_ctrl_multi;

  localparam int NB = 4;
  localparam logic [7:0] K_W = 8'h1A, K_A = 8'h04, K_S = 8'h16, K_D = 8'h07, K_SP = 8'h2C;

  logic Clk = 1'b0;
  logic Reset_n, frame_clk, can_move;
  logic [7:0] keycode;
  logic [NB-1:0] bullet_kill;
  logic [9:0] DrawX, DrawY;
  logic [9:0] tank_X, tank_Y;
  logic [2:0] tank_dir;
  logic [NB-1:0] bullet_valid;
  logic [10*NB-1:0] bullet_X, bullet_Y;
  logic [3*NB-1:0] bullet_dir;
  logic is_tank, is_bullet;
  logic [2:0] bullet_idx;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int e;

  tank_ctrl_multi #(.NUM_BULLETS(NB)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .can_move(can_move), .bullet_kill(bullet_kill), .DrawX(DrawX), .DrawY(DrawY),
    .tank_X(tank_X), .tank_Y(tank_Y), .tank_dir(tank_dir),
    .bullet_valid(bullet_valid), .bullet_X(bullet_X), .bullet_Y(bullet_Y),
    .bullet_dir(bullet_dir), .is_tank(is_tank), .is_bullet(is_bullet),
    .bullet_idx(bullet_idx)
  );

  always #10 Clk = ~Clk;

  function automatic logic [9:0] sx(int i); return bullet_X[10*i +: 10]; endfunction
  function automatic logic [9:0] sy(int i); return bullet_Y[10*i +: 10]; endfunction

  task automatic frames(input int n, input logic [7:0] k);
    for (int f = 0; f < n; f++) begin
      keycode = k;
      frame_clk = 1'b1;
      repeat (5) @(posedge Clk);
      #1 frame_clk = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
    end
  endtask

  task automatic kill_pulse(input logic [NB-1:0] m);
    bullet_kill = m;
    @(posedge Clk);
    #1 bullet_kill = '0;
  endtask

  task automatic test_reset;
    exp_q.push_back(100); exp_q.push_back(240); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back('h249);
    exp_q.push_back(1); exp_q.push_back(0);
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    e = exp_q.pop_front(); checks++; if (tank_X !== 10'(e)) begin errors++; $display("FAIL reset_x: got %0d expected %0d", tank_X, e); end
    e = exp_q.pop_front(); checks++; if (tank_Y !== 10'(e)) begin errors++; $display("FAIL reset_y: got %0d expected %0d", tank_Y, e); end
    e = exp_q.pop_front(); checks++; if (tank_dir !== 3'(e)) begin errors++; $display("FAIL reset_dir: got %0d expected %0d", tank_dir, e); end
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL reset_valid: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if ((bullet_X | bullet_Y) !== 40'(e)) begin errors++; $display("FAIL reset_bpos: got %h/%h expected 0", bullet_X, bullet_Y); end
    e = exp_q.pop_front(); checks++; if (bullet_dir !== 12'(e)) begin errors++; $display("FAIL reset_bdir: got %h expected %h", bullet_dir, e); end
    DrawX = 10'd100; DrawY = 10'd240; #1;
    e = exp_q.pop_front(); checks++; if (is_tank !== 1'(e)) begin errors++; $display("FAIL is_tank_corner: got %b expected %0d", is_tank, e); end
    DrawX = 10'd132; #1;
    e = exp_q.pop_front(); checks++; if (is_tank !== 1'(e)) begin errors++; $display("FAIL is_tank_edge: got %b expected %0d", is_tank, e); end
  endtask

  task automatic test_move;
    exp_q.push_back(110); exp_q.push_back(240); exp_q.push_back(2);
    frames(10, K_D);
    e = exp_q.pop_front(); checks++; if (tank_X !== 10'(e)) begin errors++; $display("FAIL move_x: got %0d expected %0d", tank_X, e); end
    e = exp_q.pop_front(); checks++; if (tank_Y !== 10'(e)) begin errors++; $display("FAIL move_y: got %0d expected %0d", tank_Y, e); end
    e = exp_q.pop_front(); checks++; if (tank_dir !== 3'(e)) begin errors++; $display("FAIL move_dir: got %0d expected %0d", tank_dir, e); end
    exp_q.push_back(110);
    can_move = 1'b0;
    frames(3, K_D);
    can_move = 1'b1;
    e = exp_q.pop_front(); checks++; if (tank_X !== 10'(e)) begin errors++; $display("FAIL blocked_x: got %0d expected %0d", tank_X, e); end
    exp_q.push_back(2);
    frames(1, 8'h00);
    e = exp_q.pop_front(); checks++; if (tank_dir !== 3'(e)) begin errors++; $display("FAIL nokey_dir: got %0d expected %0d", tank_dir, e); end
  endtask

  task automatic test_fire;
    // tank at (110,240) facing right: spawn (142,252)
    exp_q.push_back(1); exp_q.push_back(142); exp_q.push_back(252); exp_q.push_back(2);
    frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL fire_valid: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (sx(0) !== 10'(e)) begin errors++; $display("FAIL fire_spawn_x: got %0d expected %0d", sx(0), e); end
    e = exp_q.pop_front(); checks++; if (sy(0) !== 10'(e)) begin errors++; $display("FAIL fire_spawn_y: got %0d expected %0d", sy(0), e); end
    e = exp_q.pop_front(); checks++; if (bullet_dir[2:0] !== 3'(e)) begin errors++; $display("FAIL fire_dir: got %0d expected %0d", bullet_dir[2:0], e); end
    exp_q.push_back(1); exp_q.push_back(142 + 5*39);
    frames(39, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL hold_single_shot: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (sx(0) !== 10'(e)) begin errors++; $display("FAIL bullet_travel: got %0d expected %0d", sx(0), e); end
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    DrawX = 10'd337; DrawY = 10'd252; #1;
    e = exp_q.pop_front(); checks++; if (is_bullet !== 1'(e)) begin errors++; $display("FAIL is_bullet_in: got %b expected %0d", is_bullet, e); end
    e = exp_q.pop_front(); checks++; if (bullet_idx !== 3'(e)) begin errors++; $display("FAIL bullet_idx: got %0d expected %0d", bullet_idx, e); end
    DrawX = 10'd345; #1;
    e = exp_q.pop_front(); checks++; if (is_bullet !== 1'(e)) begin errors++; $display("FAIL is_bullet_edge: got %b expected %0d", is_bullet, e); end
    // release then new press: second shot into slot 1
    exp_q.push_back('b0011); exp_q.push_back(142);
    frames(1, 8'h00); frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL second_shot: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (sx(1) !== 10'(e)) begin errors++; $display("FAIL slot1_x: got %0d expected %0d", sx(1), e); end
    // press 4 frames later: still cooling down
    exp_q.push_back('b0011);
    frames(3, 8'h00); frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL cooldown_reject: got %b expected %0d", bullet_valid, e); end
    // press 15 frames after the shot: cooldown is 1 before this tick
    exp_q.push_back('b0011);
    frames(10, 8'h00); frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL cooldown_last_frame: got %b expected %0d", bullet_valid, e); end
    exp_q.push_back('b0111); exp_q.push_back(142);
    frames(1, 8'h00); frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL cooldown_expired: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (sx(2) !== 10'(e)) begin errors++; $display("FAIL slot2_x: got %0d expected %0d", sx(2), e); end
  endtask

  task automatic test_back_to_back;
    exp_q.push_back('b1111);
    frames(15, 8'h00); frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL pool_full: got %b expected %0d", bullet_valid, e); end
    exp_q.push_back('b1111);
    frames(15, 8'h00); frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL no_free_slot: got %b expected %0d", bullet_valid, e); end
    exp_q.push_back('b1011);
    kill_pulse(4'b0100);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL kill_slot2: got %b expected %0d", bullet_valid, e); end
    exp_q.push_back('b1111); exp_q.push_back(142); exp_q.push_back(142 + 5*92);
    frames(1, 8'h00); frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL reuse_slot2: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (sx(2) !== 10'(e)) begin errors++; $display("FAIL reuse_slot2_x: got %0d expected %0d", sx(2), e); end
    e = exp_q.pop_front(); checks++; if (sx(0) !== 10'(e)) begin errors++; $display("FAIL slot0_far_x: got %0d expected %0d", sx(0), e); end
    exp_q.push_back(0);
    kill_pulse(4'b1111);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL kill_all: got %b expected %0d", bullet_valid, e); end
  endtask

  task automatic test_bullet_retire;
    exp_q.push_back(160); exp_q.push_back(1);
    frames(80, K_W);
    e = exp_q.pop_front(); checks++; if (tank_Y !== 10'(e)) begin errors++; $display("FAIL up_y: got %0d expected %0d", tank_Y, e); end
    e = exp_q.pop_front(); checks++; if (tank_dir !== 3'(e)) begin errors++; $display("FAIL up_dir: got %0d expected %0d", tank_dir, e); end
    exp_q.push_back(122); exp_q.push_back(152);
    frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (sx(0) !== 10'(e)) begin errors++; $display("FAIL up_spawn_x: got %0d expected %0d", sx(0), e); end
    e = exp_q.pop_front(); checks++; if (sy(0) !== 10'(e)) begin errors++; $display("FAIL up_spawn_y: got %0d expected %0d", sy(0), e); end
    exp_q.push_back(1); exp_q.push_back(2);
    frames(30, 8'h00);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL up_still_valid: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (sy(0) !== 10'(e)) begin errors++; $display("FAIL up_last_y: got %0d expected %0d", sy(0), e); end
    exp_q.push_back(0); exp_q.push_back(2);
    frames(1, 8'h00);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL up_retired: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (sy(0) !== 10'(e)) begin errors++; $display("FAIL retired_keeps_y: got %0d expected %0d", sy(0), e); end
  endtask

  task automatic test_clamp_x;
    exp_q.push_back(0); exp_q.push_back(3);
    frames(115, K_A);
    e = exp_q.pop_front(); checks++; if (tank_X !== 10'(e)) begin errors++; $display("FAIL clamp_left: got %0d expected %0d", tank_X, e); end
    e = exp_q.pop_front(); checks++; if (tank_dir !== 3'(e)) begin errors++; $display("FAIL left_dir: got %0d expected %0d", tank_dir, e); end
    exp_q.push_back(608); exp_q.push_back(1); exp_q.push_back(0);
    frames(613, K_D);
    e = exp_q.pop_front(); checks++; if (tank_X !== 10'(e)) begin errors++; $display("FAIL clamp_right: got %0d expected %0d", tank_X, e); end
    DrawX = 10'd639; DrawY = 10'd170; #1;
    e = exp_q.pop_front(); checks++; if (is_tank !== 1'(e)) begin errors++; $display("FAIL is_tank_right: got %b expected %0d", is_tank, e); end
    DrawX = 10'd607; #1;
    e = exp_q.pop_front(); checks++; if (is_tank !== 1'(e)) begin errors++; $display("FAIL is_tank_left_out: got %b expected %0d", is_tank, e); end
  endtask

  task automatic test_reset_midframe;
    exp_q.push_back('b0111); exp_q.push_back(193);
    frames(1, K_S);
    frames(1, K_SP); frames(15, 8'h00);
    frames(1, K_SP); frames(15, 8'h00);
    frames(1, K_SP);
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL three_live: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (sy(2) !== 10'(e)) begin errors++; $display("FAIL down_spawn_y: got %0d expected %0d", sy(2), e); end
    exp_q.push_back(0); exp_q.push_back(100); exp_q.push_back(240); exp_q.push_back(1);
    keycode = K_D;
    frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++; if (bullet_valid !== 4'(e)) begin errors++; $display("FAIL midreset_valid: got %b expected %0d", bullet_valid, e); end
    e = exp_q.pop_front(); checks++; if (tank_X !== 10'(e)) begin errors++; $display("FAIL midreset_x: got %0d expected %0d", tank_X, e); end
    e = exp_q.pop_front(); checks++; if (tank_Y !== 10'(e)) begin errors++; $display("FAIL midreset_y: got %0d expected %0d", tank_Y, e); end
    e = exp_q.pop_front(); checks++; if (tank_dir !== 3'(e)) begin errors++; $display("FAIL midreset_dir: got %0d expected %0d", tank_dir, e); end
    exp_q.push_back(100);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    e = exp_q.pop_front(); checks++; if (tank_X !== 10'(e)) begin errors++; $display("FAIL no_tick_after_release: got %0d expected %0d", tank_X, e); end
    exp_q.push_back(101);
    frame_clk = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    frames(1, K_D);
    e = exp_q.pop_front(); checks++; if (tank_X !== 10'(e)) begin errors++; $display("FAIL first_tick_after_release: got %0d expected %0d", tank_X, e); end
  endtask

  task automatic test_clamp_y;
    exp_q.push_back(448); exp_q.push_back(4);
    frames(215, K_S);
    e = exp_q.pop_front(); checks++; if (tank_Y !== 10'(e)) begin errors++; $display("FAIL clamp_bottom: got %0d expected %0d", tank_Y, e); end
    e = exp_q.pop_front(); checks++; if (tank_dir !== 3'(e)) begin errors++; $display("FAIL down_dir: got %0d expected %0d", tank_dir, e); end
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; can_move = 1'b1;
    keycode = 8'h00; bullet_kill = '0; DrawX = '0; DrawY = '0;
    test_reset();
    test_move();
    test_fire();
    test_back_to_back();
    test_bullet_retire();
    test_clamp_x();
    test_reset_midframe();
    test_clamp_y();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tank_ctrl_multi.md
Name: tank_ctrl_multi

Overview:
Parametrised next-generation tank controller: one player tank plus a pool of NUM_BULLETS independent bullets, keyboard driven, updated once per video frame. Adds a per-player key map, a fire cooldown, edge-triggered (non-autofire) shooting, clamped rather than bounced screen edges, and per-bullet kill inputs from the collision logic. Sits between the keycode decoder and the colour mapper and collision blocks.

Parameters:
X_START, 100, tank reset X (top-left corner)
Y_START, 240, tank reset Y
KEYSET, 0, 0 = W/A/S/D + Space (0x1A/0x04/0x16/0x07, 0x2C); 1 = arrows + Enter (0x52/0x50/0x51/0x4F, 0x28)
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
TANK_SIZE, 32, tank square side
BULLET_SIZE, 8, bullet square side
TANK_STEP, 1, tank pixels per frame
BULLET_STEP, 5, bullet pixels per frame
NUM_BULLETS, 4, bullet slots (1..8)
COOLDOWN, 15, minimum frames between accepted shots

Ports:
Clk  in  1  50 MHz system clock
Reset_n  in  1  asynchronous, active-low reset
frame_clk  in  1  frame strobe (~60 Hz), asynchronous to Clk
keycode  in  8  current USB keycode (0 = none)
can_move  in  1  0 = obstacle ahead; the tank must not advance this frame
bullet_kill  in  NUM_BULLETS  per-slot retire request from collision logic
DrawX, DrawY  in  10 each  current pixel
tank_X, tank_Y  out  10 each  tank top-left
tank_dir  out  3  1 up, 2 right, 3 left, 4 down
bullet_valid  out  NUM_BULLETS  slot active
bullet_X, bullet_Y  out  10*NUM_BULLETS  packed slot positions, slot i at bits [10i+9:10i]
bullet_dir  out  3*NUM_BULLETS  packed slot directions
is_tank  out  1  pixel inside tank
is_bullet  out  1  pixel inside any valid bullet
bullet_idx  out  3  lowest-index slot covering the pixel (0 when is_bullet=0)

Behaviour:
- Reset values: tank_X=X_START, tank_Y=Y_START, tank_dir=1, all bullet_valid=0, bullet_X/Y=0, bullet_dir=1, cooldown=0, fire_prev=0. is_tank, is_bullet and bullet_idx are combinational outputs.
- frame_clk passes through a 2-flop synchroniser followed by an edge flop. tick is a 1-Clk pulse, 3 cycles after the frame_clk rise. All game state updates only on tick, except bullet_kill.
- Movement on tick: a direction key sets tank_dir and requests one step. No key or the fire key alone: no step, tank_dir held. Step is suppressed when can_move=0.
- Edge handling clamps: the new coordinate is limited to [0, SCREEN_W-TANK_SIZE] for X and [0, SCREEN_H-TANK_SIZE] for Y. Compute in 11 bits. If Y < TANK_STEP, moving up gives Y=0 (no wrap).
- Fire on tick is accepted when all of the following hold: fire key is down, fire_prev=0, cooldown=0, and some slot is invalid.
  - The lowest-index invalid slot is allocated and takes bullet_dir=tank_dir.
  - Spawn position: up (X+TS/2-BS/2, Y-BS); right (X+TS, Y+TS/2-BS/2); left (X-BS, Y+TS/2-BS/2); down (X+TS/2-BS/2, Y+TS).
  - If the spawn position would be off-screen, the shot is discarded; cooldown is still loaded.
  - fire_prev is updated to the fire-key state on every tick.
- Cooldown: loaded with COOLDOWN on an accepted shot, otherwise decremented on each tick while nonzero.
- Bullet motion on tick: each valid slot moves BULLET_STEP in its direction.
  - The slot retires (valid=0) instead of moving if the move would leave the screen: up when Y<BULLET_STEP; down when Y+BULLET_SIZE+BULLET_STEP>SCREEN_H; X axis likewise.
  - A retired slot keeps its last position.
- bullet_kill[i]: clears valid[i] on the next Clk edge in any cycle, and takes priority over a move on the same tick.
  - Kill on an invalid slot is ignored.
  - A slot killed in cycle t becomes allocatable from cycle t+1.
- Tank movement and fire evaluate the pre-tick tank position and direction. A shot spawns from the old position and old direction, even if a direction key arrives on the same tick.
- Render uses half-open ranges: is_tank when X<=DrawX<X+TANK_SIZE and Y<=DrawY<Y+TANK_SIZE; bullets use the same rule with BULLET_SIZE and only for valid slots.
- Reset_n low mid-frame: all state returns to its reset value immediately. The first tick after release occurs no earlier than the next frame_clk rise.

Decomposition:
- Package tank_pkg holds:
  - dir_t enum (UP=1, RIGHT=2, LEFT=3, DOWN=4);
  - keycode constants for both keysets;
  - a function returning the spawn offset for a dir_t.
- Sub-module tank_bullet_slot holds one bullet's valid, position, direction, step/retire logic, kill input and pixel hit output; it is instantiated NUM_BULLETS times via generate.
- The top module contains the tick synchroniser, tank movement, key decode, cooldown, the allocator (priority encoder over ~valid) and the hit OR/priority encoder.

Test Plan:
- Reset, then 10 ticks with keycode 0x07 (KEYSET=0) -> tank_X=110, tank_Y=240, tank_dir=2.
- Tank at X=0, keycode 0x04 for 5 ticks -> tank_X stays 0 with no wrap; at X=608 holding 0x07 -> stays 608.
- Hold 0x2C for 40 ticks -> exactly one shot (slot 0, spawn X=tank_X+32, Y=tank_Y+12); release, then press on tick 5 -> rejected (cooldown); press again after 15 ticks -> slot 1 allocated.
- Fill all 4 slots, press fire again -> no allocation; pulse bullet_kill[2] -> next accepted press reuses slot 2.
- Upward bullet spawned at Y=152 -> valid for 30 ticks, then retires at the tick where Y<5; bullet_Y keeps its last value.
- Assert Reset_n low mid-frame with 3 bullets live -> all valid=0, tank at (X_START,Y_START) within 1 Clk; no tick until the next frame_clk rise.
